// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared defaults and channel-state type for the multi-channel
//                clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Default number of divider channels
    localparam int c_num_ch_default = 4;

    // Default width of each channel's divisor and phase counter
    localparam int c_cnt_w_default  = 28;

    // Per-channel operating state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        INVALID = 2'd2
    } ch_state_e;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_channel
//  Description : One divide-by-N channel. Tracks a phase 0..N-1, drives a
//                registered divided clock (high for ceil(N/2) cycles), a
//                phase-0 tick and an invalid-divisor flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default
) (
    input  logic             inclk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic [CNT_W-1:0] i_finalcount,
    output logic             o_outclk,
    output logic             o_tick,
    output logic             o_err
);

    ch_state_e        r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W:0]   r_half;
    logic             r_outclk;
    logic             r_tick;
    logic             r_err;

    // One extra bit keeps phase+1 and ceil(N/2) exact even for N = 2^CNT_W-1
    logic [CNT_W:0]   w_phase_inc;
    logic [CNT_W:0]   w_half_new;
    logic             w_wrap;
    logic             w_valid;
    logic             w_load;

    assign w_phase_inc = {1'b0, r_phase} + (CNT_W+1)'(1);
    assign w_half_new  = ({1'b0, i_finalcount} + (CNT_W+1)'(1)) >> 1;
    assign w_wrap      = (w_phase_inc == {1'b0, r_n});
    assign w_valid     = (i_finalcount > CNT_W'(1));
    // Phase 0 is (re)entered on start-up, on wrap, on sync, and every cycle
    // while the divisor is invalid so a corrected value is picked up at once.
    assign w_load      = (r_state != RUN) || i_sync || w_wrap;

    // Channel state machine with registered outputs
    always_ff @(posedge inclk) begin
        if (!reset_n || !i_enable) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_n      <= '0;
            r_half   <= '0;
            r_outclk <= 1'b0;
            r_tick   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_phase <= '0;
            if (w_valid) begin
                r_state  <= RUN;
                r_n      <= i_finalcount;
                r_half   <= w_half_new;
                r_outclk <= 1'b1;
                r_tick   <= 1'b1;
                r_err    <= 1'b0;
            end else begin
                r_state  <= INVALID;
                r_outclk <= 1'b0;
                r_tick   <= 1'b0;
                r_err    <= 1'b1;
            end
        end else begin
            r_phase  <= w_phase_inc[CNT_W-1:0];
            r_outclk <= (w_phase_inc < r_half);
            r_tick   <= 1'b0;
        end
    end

    assign o_outclk = r_outclk;
    assign o_tick   = r_tick;
    assign o_err    = r_err;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/multi_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_clk_divider
//  Description : NUM_CH independent programmable clock dividers sharing one
//                input clock, reset and a common phase-restart (sync).
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = c_num_ch_default,
    parameter int CNT_W  = c_cnt_w_default
) (
    input  logic                    inclk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] finalcount,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       outclk,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       err
);

    // One divider per channel, each fed its own divisor slice
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .inclk        (inclk),
            .reset_n      (reset_n),
            .i_enable     (enable[gi]),
            .i_sync       (sync),
            .i_finalcount (finalcount[gi*CNT_W +: CNT_W]),
            .o_outclk     (outclk[gi]),
            .o_tick       (tick[gi]),
            .o_err        (err[gi])
        );
    end

endmodule : multi_clk_divider
`default_nettype wire
